stream_fifo_write_sequencer: RTL and testbench

- Sequences the write side of the stream FIFO controller.
- Converts a byte stream with frame delimiters (s_valid/s_ready/s_last) into the controller's 3-bit w_ctrl command codes.
- Builds a 2-byte length header for each good frame, issues DISCARD for bad or oversize frames, and keeps good/dropped frame counters.
- Sits between the packet source and the w_clk domain of the stream async FIFO, in the same clock domain as the write side.

---
 rtl/stream_fifo_write_sequencer_if.sv | 28 ++
 rtl/stream_fifo_write_sequencer.sv | 150 +++++++++++++++
 tb/tb_stream_fifo_write_sequencer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/stream_fifo_write_sequencer_if.sv
// stream_fifo_write_sequencer_if
// Groups the byte-stream input handshake and the FIFO write-command bus
// of the write sequencer.
//   s_valid/s_ready/s_data/s_last/s_empty/s_err : framed byte stream
//   w_ctrl/w_data/w_full                        : FIFO write command bus
// slave  : the sequencer's view (consumes the stream, drives the FIFO bus)
// master : the surrounding view (packet source plus FIFO controller)
interface stream_fifo_write_sequencer_if;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       s_last;
    logic       s_empty;
    logic       s_err;
    logic [2:0] w_ctrl;
    logic [7:0] w_data;
    logic       w_full;

    modport slave (
        input  s_valid, s_data, s_last, s_empty, s_err, w_full,
        output s_ready, w_ctrl, w_data
    );

    modport master (
        output s_valid, s_data, s_last, s_empty, s_err, w_full,
        input  s_ready, w_ctrl, w_data
    );
endinterface

// File: rtl/stream_fifo_write_sequencer.sv
// stream_fifo_write_sequencer
// Turns a framed byte stream into the stream FIFO controller's 3-bit write
// commands. Good frames are followed by a 2-byte big-endian length header;
// errored, oversize and zero-length frames are discarded.
// Ports:
//   clk            write-side clock
//   rst            asynchronous active-high reset
//   bus            stream input + FIFO command bus (slave modport)
//   busy           sequencer is not idle
//   frames_ok      committed frame count (wraps)
//   frames_dropped discarded frame count (wraps)
module stream_fifo_write_sequencer #(
    parameter int MAX_LEN = 1500,
    parameter int CNTW    = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    stream_fifo_write_sequencer_if.slave  bus,
    output logic                          busy,
    output logic [CNTW-1:0]               frames_ok,
    output logic [CNTW-1:0]               frames_dropped
);

    localparam logic [2:0] CMD_NOP        = 3'd0;
    localparam logic [2:0] CMD_WRITE      = 3'd1;
    localparam logic [2:0] CMD_EOF_WRITE  = 3'd2;
    localparam logic [2:0] CMD_EOF_NOWR   = 3'd3;
    localparam logic [2:0] CMD_HEAD       = 3'd4;
    localparam logic [2:0] CMD_FINAL_HEAD = 3'd5;
    localparam logic [2:0] CMD_DISCARD    = 3'd6;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_PAYLOAD = 3'd1;
    localparam logic [2:0] ST_HDR_HI  = 3'd2;
    localparam logic [2:0] ST_HDR_LO  = 3'd3;
    localparam logic [2:0] ST_DROP    = 3'd4;

    localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);

    logic [2:0]      state_reg, state_next;
    logic [15:0]     len_reg, len_next;
    logic [CNTW-1:0] ok_reg, drop_reg;
    logic            ok_inc, drop_inc;
    logic            ready_c, accept;
    logic [2:0]      ctrl_c;
    logic [7:0]      data_c;
    logic            byte_beat;

    // Ready is forced low during reset so nothing is consumed while the
    // FIFO controller is also being reset.
    always_comb begin
        ready_c = 1'b0;
        if (!rst) begin
            case (state_reg)
                ST_IDLE, ST_PAYLOAD: ready_c = !bus.w_full;
                ST_DROP:             ready_c = 1'b1;
                default:             ready_c = 1'b0;
            endcase
        end
    end

    assign accept = bus.s_valid && ready_c;
    // A final beat flagged empty carries no byte; s_empty alone is ignored.
    assign byte_beat = !(bus.s_last && bus.s_empty);

    always_comb begin
        state_next = state_reg;
        len_next   = len_reg;
        ctrl_c     = CMD_NOP;
        data_c     = 8'h00;
        ok_inc     = 1'b0;
        drop_inc   = 1'b0;
        case (state_reg)
            ST_IDLE, ST_PAYLOAD: begin
                if (accept) begin
                    state_next = ST_PAYLOAD;
                    if (bus.s_err || (len_reg == MAX_LEN_W && byte_beat)) begin
                        ctrl_c     = CMD_DISCARD;
                        drop_inc   = 1'b1;
                        len_next   = 16'd0;
                        state_next = bus.s_last ? ST_IDLE : ST_DROP;
                    end else if (!byte_beat && len_reg == 16'd0) begin
                        ctrl_c     = CMD_DISCARD;
                        drop_inc   = 1'b1;
                        state_next = ST_IDLE;
                    end else if (!byte_beat) begin
                        ctrl_c     = CMD_EOF_NOWR;
                        state_next = ST_HDR_HI;
                    end else if (bus.s_last) begin
                        ctrl_c     = CMD_EOF_WRITE;
                        data_c     = bus.s_data;
                        len_next   = len_reg + 16'd1;
                        state_next = ST_HDR_HI;
                    end else begin
                        ctrl_c     = CMD_WRITE;
                        data_c     = bus.s_data;
                        len_next   = len_reg + 16'd1;
                    end
                end
            end
            ST_HDR_HI: begin
                if (!bus.w_full) begin
                    ctrl_c     = CMD_HEAD;
                    data_c     = len_reg[15:8];
                    state_next = ST_HDR_LO;
                end
            end
            ST_HDR_LO: begin
                if (!bus.w_full) begin
                    ctrl_c     = CMD_FINAL_HEAD;
                    data_c     = len_reg[7:0];
                    ok_inc     = 1'b1;
                    len_next   = 16'd0;
                    state_next = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (accept && bus.s_last) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                len_next   = 16'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            len_reg   <= 16'd0;
            ok_reg    <= '0;
            drop_reg  <= '0;
        end else begin
            state_reg <= state_next;
            len_reg   <= len_next;
            if (ok_inc)   ok_reg   <= ok_reg + 1'b1;
            if (drop_inc) drop_reg <= drop_reg + 1'b1;
        end
    end

    assign bus.s_ready     = ready_c;
    assign bus.w_ctrl      = ctrl_c;
    assign bus.w_data      = data_c;
    assign busy            = (state_reg != ST_IDLE);
    assign frames_ok       = ok_reg;
    assign frames_dropped  = drop_reg;

endmodule

// File: tb/tb_stream_fifo_write_sequencer.sv
// Directed bench for stream_fifo_write_sequencer with MAX_LEN = 4.
// Inputs change on the falling edge; combinational outputs are sampled
// 1 ns later, ahead of the rising edge that commits the beat.
module tb_stream_fifo_write_sequencer;

    localparam logic [2:0] NOP = 3'd0, WR = 3'd1, EOFW = 3'd2, EOFN = 3'd3,
                           HEAD = 3'd4, FHEAD = 3'd5, DISC = 3'd6;

    logic        clk = 1'b0;
    logic        rst;
    logic        busy;
    logic [15:0] frames_ok, frames_dropped;
    int          n_checks = 0;
    int          n_pass = 0;

    stream_fifo_write_sequencer_if bus();

    stream_fifo_write_sequencer #(.MAX_LEN(4), .CNTW(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus.slave),
        .busy           (busy),
        .frames_ok      (frames_ok),
        .frames_dropped (frames_dropped)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // One cycle: apply inputs, check ready/command/data before the edge.
    task automatic step(input string tag, input logic v, input logic [7:0] d,
                        input logic l, input logic e, input logic er, input logic full,
                        input logic exp_rdy, input logic [2:0] exp_ctrl,
                        input logic [7:0] exp_data);
        @(negedge clk);
        bus.s_valid = v;
        bus.s_data  = d;
        bus.s_last  = l;
        bus.s_empty = e;
        bus.s_err   = er;
        bus.w_full  = full;
        #1;
        check({tag, ".rdy"},  32'(bus.s_ready), 32'(exp_rdy));
        check({tag, ".ctrl"}, 32'(bus.w_ctrl),  32'(exp_ctrl));
        check({tag, ".data"}, 32'(bus.w_data),  32'(exp_data));
        $display("beat %s v=%0b d=%02h last=%0b empty=%0b err=%0b full=%0b -> rdy=%0b ctrl=%0d data=%02h",
                 tag, v, d, l, e, er, full, bus.s_ready, bus.w_ctrl, bus.w_data);
    endtask

    initial begin
        rst = 1'b1;
        bus.s_valid = 1'b1; bus.s_data = 8'h55; bus.s_last = 1'b0;
        bus.s_empty = 1'b0; bus.s_err = 1'b0; bus.w_full = 1'b0;
        #3;
        check("rst.rdy",   32'(bus.s_ready), 0);
        check("rst.ctrl",  32'(bus.w_ctrl), 0);
        check("rst.data",  32'(bus.w_data), 0);
        check("rst.busy",  32'(busy), 0);
        check("rst.ok",    32'(frames_ok), 0);
        check("rst.drop",  32'(frames_dropped), 0);
        @(negedge clk);
        rst = 1'b0;
        bus.s_valid = 1'b0;

        // Good frame 00,01,02
        step("g0", 1, 8'h00, 0, 0, 0, 0, 1, WR,   8'h00);
        step("g1", 1, 8'h01, 0, 0, 0, 0, 1, WR,   8'h01);
        step("g2", 1, 8'h02, 1, 0, 0, 0, 1, EOFW, 8'h02);
        step("gh", 0, 8'h00, 0, 0, 0, 0, 0, HEAD, 8'h00);
        check("g.busy", 32'(busy), 1);
        step("gl", 0, 8'h00, 0, 0, 0, 0, 0, FHEAD, 8'h03);

        // Empty final beat; first beat lands right after FINAL_HEAD
        step("e0", 1, 8'h10, 0, 0, 0, 0, 1, WR,    8'h10);
        check("g.ok", 32'(frames_ok), 1);
        step("e1", 1, 8'h11, 0, 0, 0, 0, 1, WR,    8'h11);
        step("e2", 1, 8'hEE, 1, 1, 0, 0, 1, EOFN,  8'h00);
        step("eh", 0, 8'h00, 0, 0, 0, 0, 0, HEAD,  8'h00);
        step("el", 0, 8'h00, 0, 0, 0, 0, 0, FHEAD, 8'h02);

        // Error on beat 2 of 5; DROP ignores w_full
        step("x0", 1, 8'hA0, 0, 0, 0, 0, 1, WR,   8'hA0);
        step("x1", 1, 8'hA1, 0, 0, 1, 0, 1, DISC, 8'h00);
        step("x2", 1, 8'hA2, 0, 0, 0, 0, 1, NOP,  8'h00);
        step("x3", 1, 8'hA3, 0, 0, 0, 1, 1, NOP,  8'h00);
        step("x4", 1, 8'hA4, 1, 0, 0, 0, 1, NOP,  8'h00);
        @(negedge clk); bus.s_valid = 1'b0; #1;
        check("x.drop", 32'(frames_dropped), 1);
        check("x.busy", 32'(busy), 0);

        // Exactly MAX_LEN bytes is good
        step("m0", 1, 8'h30, 0, 0, 0, 0, 1, WR,    8'h30);
        step("m1", 1, 8'h31, 0, 0, 0, 0, 1, WR,    8'h31);
        step("m2", 1, 8'h32, 0, 0, 0, 0, 1, WR,    8'h32);
        step("m3", 1, 8'h33, 1, 0, 0, 0, 1, EOFW,  8'h33);
        step("mh", 0, 8'h00, 0, 0, 0, 0, 0, HEAD,  8'h00);
        step("ml", 0, 8'h00, 0, 0, 0, 0, 0, FHEAD, 8'h04);

        // 6-byte frame: discard on byte 5, byte 6 dropped
        step("o0", 1, 8'h40, 0, 0, 0, 0, 1, WR,   8'h40);
        step("o1", 1, 8'h41, 0, 0, 0, 0, 1, WR,   8'h41);
        step("o2", 1, 8'h42, 0, 0, 0, 0, 1, WR,   8'h42);
        step("o3", 1, 8'h43, 0, 0, 0, 0, 1, WR,   8'h43);
        step("o4", 1, 8'h44, 0, 0, 0, 0, 1, DISC, 8'h00);
        step("o5", 1, 8'h45, 1, 0, 0, 0, 1, NOP,  8'h00);

        // Zero-length frame
        step("z0", 1, 8'h00, 1, 1, 0, 0, 1, DISC, 8'h00);
        @(negedge clk); bus.s_valid = 1'b0; #1;
        check("z.drop", 32'(frames_dropped), 3);
        check("z.busy", 32'(busy), 0);

        // 4 bytes then an empty last beat at len == MAX_LEN: still good
        step("b0", 1, 8'h50, 0, 0, 0, 0, 1, WR,    8'h50);
        step("b1", 1, 8'h51, 0, 0, 0, 0, 1, WR,    8'h51);
        step("b2", 1, 8'h52, 0, 0, 0, 0, 1, WR,    8'h52);
        step("b3", 1, 8'h53, 0, 0, 0, 0, 1, WR,    8'h53);
        step("b4", 1, 8'h00, 1, 1, 0, 0, 1, EOFN,  8'h00);
        step("bh", 0, 8'h00, 0, 0, 0, 0, 0, HEAD,  8'h00);
        step("bl", 0, 8'h00, 0, 0, 0, 0, 0, FHEAD, 8'h04);

        // Backpressure in PAYLOAD and HDR_HI; s_empty without s_last is data
        step("p0",  1, 8'h60, 0, 1, 0, 0, 1, WR,    8'h60);
        step("pf0", 1, 8'h61, 0, 0, 0, 1, 0, NOP,   8'h00);
        step("pf1", 1, 8'h61, 0, 0, 0, 1, 0, NOP,   8'h00);
        step("pf2", 1, 8'h61, 0, 0, 0, 1, 0, NOP,   8'h00);
        step("p1",  1, 8'h61, 0, 0, 0, 0, 1, WR,    8'h61);
        step("p2",  1, 8'h62, 1, 0, 0, 0, 1, EOFW,  8'h62);
        step("hf0", 0, 8'h00, 0, 0, 0, 1, 0, NOP,   8'h00);
        step("hf1", 0, 8'h00, 0, 0, 0, 1, 0, NOP,   8'h00);
        step("hf2", 0, 8'h00, 0, 0, 0, 1, 0, NOP,   8'h00);
        step("ph",  0, 8'h00, 0, 0, 0, 0, 0, HEAD,  8'h00);
        step("pl",  0, 8'h00, 0, 0, 0, 0, 0, FHEAD, 8'h03);
        @(negedge clk); bus.s_valid = 1'b0; #1;
        check("p.ok",   32'(frames_ok), 5);
        check("p.drop", 32'(frames_dropped), 3);

        // Async reset while in HDR_LO
        step("r0", 1, 8'h70, 1, 0, 0, 0, 1, EOFW, 8'h70);
        step("rh", 0, 8'h00, 0, 0, 0, 0, 0, HEAD, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("ar.ctrl", 32'(bus.w_ctrl), 0);
        check("ar.data", 32'(bus.w_data), 0);
        check("ar.rdy",  32'(bus.s_ready), 0);
        check("ar.busy", 32'(busy), 0);
        check("ar.ok",   32'(frames_ok), 0);
        check("ar.drop", 32'(frames_dropped), 0);
        @(negedge clk);
        rst = 1'b0;
        step("ri", 0, 8'h00, 0, 0, 0, 0, 1, NOP, 8'h00);
        check("ri.ok", 32'(frames_ok), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
